// File: rtl/gf16_mac_seq.sv
// Bit-serial GF(2^4) multiply-accumulate: Horner product, XOR accumulator, valid/ready result.
// Optional feature macro: GF16_MAC_ZERO_SKIP_EN (zero operands bypass the multiply steps).
module gf16_mac_seq #(
    parameter logic [3:0] POLY     = 4'b0011,
    parameter logic [3:0] ACC_INIT = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_clr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_prod,
    output logic [3:0] out_acc,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg;
    logic [3:0] p_reg;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic       clr_reg;
    logic [3:0] acc_reg;
    logic [3:0] prod_reg;
    logic       valid_reg;

    logic       accept;
    logic       zero_op;
    logic       b_bit;
    logic [3:0] xt;
    logic [3:0] pp;
    logic [3:0] p_next;
    logic [3:0] fold_in;
    logic       fold_clr;
    logic [3:0] acc_next;

    assign accept = in_valid & in_ready;

`ifdef GF16_MAC_ZERO_SKIP_EN
    assign zero_op = (in_a == 4'h0) | (in_b == 4'h0);
`else
    assign zero_op = 1'b0;
`endif

    // One Horner step: shift-and-reduce, then add a_reg if the current multiplier bit is set.
    assign b_bit = b_reg[2'd3 - cnt_reg];
    assign xt    = {p_reg[2:0], 1'b0} ^ (p_reg[3] ? POLY : 4'h0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = a_reg[gi] & b_bit;
        end
    endgenerate

    assign p_next = xt ^ pp;

    // In IDLE only the zero-skip path folds, with a zero product and the live clr input.
    assign fold_in  = (state_reg == IDLE) ? 4'h0 : p_next;
    assign fold_clr = (state_reg == IDLE) ? in_clr : clr_reg;
    assign acc_next = fold_clr ? fold_in : (acc_reg ^ fold_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = zero_op ? DONE : MUL;
            MUL:  if (cnt_reg == 2'd3) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE) & ~rst;
        busy      = (state_reg != IDLE);
        out_valid = valid_reg;
        out_prod  = prod_reg;
        out_acc   = acc_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= 2'd0;
            p_reg     <= 4'h0;
            a_reg     <= 4'h0;
            b_reg     <= 4'h0;
            clr_reg   <= 1'b0;
            acc_reg   <= ACC_INIT;
            prod_reg  <= 4'h0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        clr_reg <= in_clr;
                        p_reg   <= 4'h0;
                        cnt_reg <= 2'd0;
                        if (zero_op) begin
                            prod_reg  <= 4'h0;
                            acc_reg   <= acc_next;
                            valid_reg <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    p_reg   <= p_next;
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        prod_reg  <= p_next;
                        acc_reg   <= acc_next;
                        valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) valid_reg <= 1'b0;
                end
                default: valid_reg <= 1'b0;
            endcase
        end
    end

endmodule
